// File: rtl/proc_control_fsm_if.sv
// -----------------------------------------------------------------------------
// proc_control_fsm_if
// Bundle between the processor control unit and its datapath environment.
//   Run    : start request, sampled by the controller only in T0
//   DIN    : external data; DIN[8:0] is the instruction word in T0
//   Rout   : one-hot register-to-bus select (bit i selects Ri)
//   Gout   : G register to bus
//   DINout : DIN to bus
//   Rin    : one-hot register load enable (bit i loads Ri from the bus)
//   Ain    : A register load from the bus
//   Gin    : G register load from the ALU
//   AddSub : ALU op, 0 = A+bus, 1 = A-bus
//   Done   : one-cycle pulse in the final step of each instruction
// Modport master is the controller; modport slave is the datapath/environment.
// -----------------------------------------------------------------------------
interface proc_control_fsm_if #(
    parameter int DIN_W = 16
);
    logic             Run;
    logic [DIN_W-1:0] DIN;
    logic [7:0]       Rout;
    logic             Gout;
    logic             DINout;
    logic [7:0]       Rin;
    logic             Ain;
    logic             Gin;
    logic             AddSub;
    logic             Done;

    modport master (
        input  Run, DIN,
        output Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done
    );

    modport slave (
        output Run, DIN,
        input  Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done
    );
endinterface

// File: rtl/proc_control_fsm.sv
// -----------------------------------------------------------------------------
// proc_control_fsm
// Control unit of the 16-bit simple processor. Latches a 9-bit instruction
// {III, XXX, YYY} from DIN in T0 and sequences it through T1..T3, driving the
// bus-source selects, register/A/G load enables and the ALU add/sub control.
// Ports:
//   Clock  : system clock, rising edge
//   Resetn : asynchronous reset, active low
//   bus    : proc_control_fsm_if.master (Run, DIN in; control selects out)
// Outputs are decoded from the step and IR registers only, so they never
// depend combinationally on Run or DIN and drop to zero as soon as Resetn
// is asserted.
// -----------------------------------------------------------------------------
module proc_control_fsm #(
    parameter int DIN_W = 16
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    proc_control_fsm_if.master        bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Register index to one-hot select.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'b0000_0001 << idx;
    endfunction

    step_t      step_q, step_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] op_s, rx_s, ry_s;
    logic       is_arith_s;

    logic [7:0] rout_s, rin_s;
    logic       gout_s, dinout_s, ain_s, gin_s, addsub_s, done_s;

    assign op_s       = ir_q[8:6];
    assign rx_s       = ir_q[5:3];
    assign ry_s       = ir_q[2:0];
    assign is_arith_s = (op_s == OP_ADD) || (op_s == OP_SUB);

    // Only DIN[8:0] carries the instruction; the upper bits reach the
    // registers through the bus mux, not through this block.
    if (DIN_W > 9) begin : g_din_hi
        logic unused_din_hi_s;
        assign unused_din_hi_s = ^bus.DIN[DIN_W-1:9];
    end

    // Next step and IR; Run and DIN are only looked at in T0.
    always_comb begin
        step_d = T0;
        ir_d   = ir_q;
        case (step_q)
            T0: begin
                if (bus.Run) begin
                    ir_d   = bus.DIN[8:0];
                    step_d = T1;
                end else begin
                    step_d = T0;
                end
            end
            T1: begin
                if (is_arith_s) begin
                    step_d = T2;
                end else begin
                    step_d = T0;
                end
            end
            T2: begin
                if (is_arith_s) begin
                    step_d = T3;
                end else begin
                    step_d = T0;
                end
            end
            T3:      step_d = T0;
            default: step_d = T0;
        endcase
    end

    // Step and IR state registers with asynchronous reset to T0 / IR=0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
            ir_q   <= 9'd0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    // Control decode from step and IR; at most one bus source is selected.
    always_comb begin
        rout_s   = 8'h00;
        rin_s    = 8'h00;
        gout_s   = 1'b0;
        dinout_s = 1'b0;
        ain_s    = 1'b0;
        gin_s    = 1'b0;
        addsub_s = 1'b0;
        done_s   = 1'b0;
        case (step_q)
            T0: begin
                done_s = 1'b0;
            end
            T1: begin
                case (op_s)
                    OP_MV: begin
                        rout_s = onehot8(ry_s);
                        rin_s  = onehot8(rx_s);
                        done_s = 1'b1;
                    end
                    OP_MVI: begin
                        dinout_s = 1'b1;
                        rin_s    = onehot8(rx_s);
                        done_s   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_s = onehot8(rx_s);
                        ain_s  = 1'b1;
                    end
                    default: begin
                        // Invalid opcode: finish immediately with no bus traffic.
                        done_s = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_arith_s) begin
                    rout_s   = onehot8(ry_s);
                    gin_s    = 1'b1;
                    addsub_s = ir_q[6];
                end else begin
                    gin_s = 1'b0;
                end
            end
            T3: begin
                if (is_arith_s) begin
                    gout_s = 1'b1;
                    rin_s  = onehot8(rx_s);
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    assign bus.Rout   = rout_s;
    assign bus.Gout   = gout_s;
    assign bus.DINout = dinout_s;
    assign bus.Rin    = rin_s;
    assign bus.Ain    = ain_s;
    assign bus.Gin    = gin_s;
    assign bus.AddSub = addsub_s;
    assign bus.Done   = done_s;

endmodule

// File: tb/tb_proc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_proc_control_fsm
// Scoreboard bench for proc_control_fsm. The stimulus process drives Run/DIN/
// Resetn one cycle at a time just after each rising edge and pushes the
// hand-computed output vector expected for that cycle. A monitor on the
// falling edge pops one entry per cycle and compares the full output bundle.
// Vector layout: {Rout[7:0], Gout, DINout, Rin[7:0], Ain, Gin, AddSub, Done}.
// -----------------------------------------------------------------------------
module tb_proc_control_fsm;

    logic Clock;
    logic Resetn;

    proc_control_fsm_if #(.DIN_W(16)) bus ();

    proc_control_fsm #(.DIN_W(16)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        logic [21:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run;
    int   tests_failed;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [21:0] mk(input logic [7:0] rout, input logic gout,
                                       input logic dinout, input logic [7:0] rin,
                                       input logic ain, input logic gin,
                                       input logic addsub, input logic done);
        mk = {rout, gout, dinout, rin, ain, gin, addsub, done};
    endfunction

    localparam logic [21:0] ZERO = 22'd0;

    // Drive one cycle of inputs and record the outputs expected during it.
    task automatic cyc(input logic rstn, input logic run, input logic [15:0] din,
                       input logic [21:0] exp_vec, input string name);
        exp_t e;
        Resetn   = rstn;
        bus.Run  = run;
        bus.DIN  = din;
        e.name   = name;
        e.vec    = exp_vec;
        sb_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    // Monitor: compare DUT outputs against the scoreboard mid-cycle.
    always @(negedge Clock) begin
        exp_t        e;
        logic [21:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {bus.Rout, bus.Gout, bus.DINout, bus.Rin,
                   bus.Ain, bus.Gin, bus.AddSub, bus.Done};
            tests_run++;
            if (act !== e.vec) begin
                tests_failed++;
                $display("FAIL %s: got %06h expected %06h", e.name, act, e.vec);
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Resetn       = 1'b0;
        bus.Run      = 1'b0;
        bus.DIN      = 16'h0000;
        @(posedge Clock);
        #1;

        // Reset state
        cyc(1'b0, 1'b0, 16'h0000, ZERO, "reset_0");
        cyc(1'b0, 1'b1, 16'h0015, ZERO, "reset_run_ignored");
        cyc(1'b1, 1'b0, 16'h0015, ZERO, "idle_t0");

        // mv R2,R5
        cyc(1'b1, 1'b1, 16'h0015, ZERO, "mv_t0");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h20, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1), "mv_t1");
        cyc(1'b1, 1'b0, 16'h0000, ZERO, "mv_back_t0");

        // mvi R0,#0x1234
        cyc(1'b1, 1'b1, 16'h0040, ZERO, "mvi_t0");
        cyc(1'b1, 1'b0, 16'h1234, mk(8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1), "mvi_t1");
        cyc(1'b1, 1'b0, 16'h0000, ZERO, "mvi_back_t0");

        // add R1,R3
        cyc(1'b1, 1'b1, 16'h008B, ZERO, "add_t0");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "add_t1");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), "add_t2");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1), "add_t3");
        cyc(1'b1, 1'b0, 16'h0000, ZERO, "add_back_t0");

        // sub R7,R7 with Run held high, then mv R2,R5 back to back
        cyc(1'b1, 1'b1, 16'h00FF, ZERO, "sub_t0");
        cyc(1'b1, 1'b1, 16'h0015, mk(8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "sub_t1");
        cyc(1'b1, 1'b1, 16'h0015, mk(8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), "sub_t2");
        cyc(1'b1, 1'b1, 16'h0015, mk(8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1), "sub_t3");
        cyc(1'b1, 1'b1, 16'h0015, ZERO, "b2b_t0");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h20, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1), "b2b_mv_t1");
        cyc(1'b1, 1'b0, 16'h0000, ZERO, "b2b_back_t0");

        // mv R3,R3 (x == y)
        cyc(1'b1, 1'b1, 16'h001B, ZERO, "mvself_t0");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h08, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1), "mvself_t1");

        // Invalid opcode 0x1C0
        cyc(1'b1, 1'b1, 16'h01C0, ZERO, "inv_t0");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1), "inv_t1");
        cyc(1'b1, 1'b0, 16'h0000, ZERO, "inv_back_t0");

        // add R1,R3 abandoned by reset during T2
        cyc(1'b1, 1'b1, 16'h008B, ZERO, "rst_add_t0");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "rst_add_t1");
        cyc(1'b0, 1'b0, 16'h0000, ZERO, "rst_async_t2");
        cyc(1'b0, 1'b0, 16'h0000, ZERO, "rst_held");
        cyc(1'b1, 1'b0, 16'h0000, ZERO, "rst_idle_0");
        cyc(1'b1, 1'b0, 16'h008B, ZERO, "rst_idle_1");
        cyc(1'b1, 1'b1, 16'h0015, ZERO, "rst_restart_t0");
        cyc(1'b1, 1'b0, 16'h0000, mk(8'h20, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1), "rst_restart_t1");
        cyc(1'b1, 1'b0, 16'h0000, ZERO, "final_t0");

        // Let the monitor drain the last entry.
        @(negedge Clock);
        #1;
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
